// File: rtl/itvm_change_dispenser_if.sv
// Note-hopper handshake between the change dispenser and the hopper.
// The dispenser (master) raises eject_req with a denomination code in
// eject_note; the hopper (slave) answers with eject_ack once the note is out.
interface itvm_change_dispenser_if;
  logic       eject_req;
  logic [1:0] eject_note;
  logic       eject_ack;

  modport master (output eject_req, output eject_note, input eject_ack);
  modport slave  (input eject_req, input eject_note, output eject_ack);
endinterface

// File: rtl/itvm_change_dispenser.sv
// Change dispenser for the ticket vending machine.
// Pays a refund one note at a time, choosing the largest note (1000, 500, 100, 50)
// that still fits the unpaid balance and is in stock. Faults on an amount that is
// not a multiple of 50, on running out of suitable notes, or on a hopper that
// does not acknowledge within TIMEOUT cycles.
module itvm_change_dispenser #(
  parameter int AMT_W   = 14,
  parameter int INV_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [AMT_W-1:0]       amount,
  input  logic                   refill_en,
  input  logic [1:0]             refill_note,
  input  logic [INV_W-1:0]       refill_qty,
  input  logic                   clr,
  output logic                   busy,
  output logic                   done,
  output logic                   fault,
  output logic [AMT_W-1:0]       remaining,
  output logic [INV_W-1:0]       inv50,
  output logic [INV_W-1:0]       inv100,
  output logic [INV_W-1:0]       inv500,
  output logic [INV_W-1:0]       inv1000,
  itvm_change_dispenser_if.master hopper
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SELECT = 3'd1;
  localparam logic [2:0] EJECT  = 3'd2;
  localparam logic [2:0] DONE   = 3'd3;
  localparam logic [2:0] FAULT  = 3'd4;

  // Face value in taka of a denomination code.
  function automatic logic [AMT_W-1:0] denom_value(input logic [1:0] code);
    logic [AMT_W-1:0] v;
    case (code)
      2'd0:    v = AMT_W'(50);
      2'd1:    v = AMT_W'(100);
      2'd2:    v = AMT_W'(500);
      2'd3:    v = AMT_W'(1000);
      default: v = AMT_W'(1000);
    endcase
    return v;
  endfunction

  // Inventory add that pins at the counter maximum instead of wrapping.
  function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                               input logic [INV_W-1:0] b);
    logic [INV_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[INV_W]) begin
      return {INV_W{1'b1}};
    end else begin
      return s[INV_W-1:0];
    end
  endfunction

  logic [2:0]       state_r;
  logic [2:0]       state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [AMT_W-1:0] remaining_r;
  logic [1:0]       note_r;
  logic [INV_W-1:0] inv_r [4];
  logic             busy_r;
  logic             done_r;
  logic             fault_r;
  logic             eject_req_r;
  logic             sel_ok_s;
  logic [1:0]       sel_code_s;
  logic             ack_s;
  logic             bad_amount_s;
  logic             refill_ok_s;

  assign ack_s        = hopper.eject_ack && (state_r == EJECT);
  assign bad_amount_s = (amount % AMT_W'(50)) != {AMT_W{1'b0}};
  assign refill_ok_s  = refill_en && ((state_r == IDLE) || (state_r == FAULT));

  // Greedy pick: largest in-stock note not exceeding the unpaid balance.
  always_comb begin
    sel_ok_s   = 1'b0;
    sel_code_s = 2'd0;
    if ((inv_r[3] != {INV_W{1'b0}}) && (remaining_r >= denom_value(2'd3))) begin
      sel_ok_s   = 1'b1;
      sel_code_s = 2'd3;
    end else if ((inv_r[2] != {INV_W{1'b0}}) && (remaining_r >= denom_value(2'd2))) begin
      sel_ok_s   = 1'b1;
      sel_code_s = 2'd2;
    end else if ((inv_r[1] != {INV_W{1'b0}}) && (remaining_r >= denom_value(2'd1))) begin
      sel_ok_s   = 1'b1;
      sel_code_s = 2'd1;
    end else if ((inv_r[0] != {INV_W{1'b0}}) && (remaining_r >= denom_value(2'd0))) begin
      sel_ok_s   = 1'b1;
      sel_code_s = 2'd0;
    end else begin
      sel_ok_s   = 1'b0;
      sel_code_s = 2'd0;
    end
  end

  // Next-state decision; an ack in the last wait cycle beats the timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = bad_amount_s ? FAULT : SELECT;
        end else begin
          state_s = IDLE;
        end
      end
      SELECT: begin
        if (remaining_r == {AMT_W{1'b0}}) begin
          state_s = DONE;
        end else if (sel_ok_s) begin
          state_s = EJECT;
        end else begin
          state_s = FAULT;
        end
      end
      EJECT: begin
        if (ack_s) begin
          state_s = SELECT;
        end else if (cnt_r == CNT_W'(TIMEOUT)) begin
          state_s = FAULT;
        end else begin
          state_s = EJECT;
        end
      end
      DONE:    state_s = IDLE;
      FAULT:   state_s = clr ? IDLE : FAULT;
      default: state_s = IDLE;
    endcase
  end

  // State register and Moore output flags, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fault_r     <= 1'b0;
      eject_req_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      busy_r      <= (state_s == SELECT) || (state_s == EJECT);
      done_r      <= (state_s == DONE);
      fault_r     <= (state_s == FAULT);
      eject_req_r <= (state_s == EJECT);
    end
  end

  // Balance, selected note and acknowledge-wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_r <= {AMT_W{1'b0}};
      note_r      <= 2'd0;
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            remaining_r <= amount;
          end
        end
        SELECT: begin
          cnt_r <= {CNT_W{1'b0}};
          if (sel_ok_s) begin
            note_r <= sel_code_s;
          end
        end
        EJECT: begin
          if (ack_s) begin
            remaining_r <= remaining_r - denom_value(note_r);
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Per-denomination stock: decrement on a paid note, saturating refill when idle or faulted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        inv_r[i] <= {INV_W{1'b0}};
      end
    end else if (ack_s) begin
      inv_r[note_r] <= inv_r[note_r] - INV_W'(1);
    end else if (refill_ok_s) begin
      inv_r[refill_note] <= sat_add(inv_r[refill_note], refill_qty);
    end
  end

  assign busy              = busy_r;
  assign done              = done_r;
  assign fault             = fault_r;
  assign remaining         = remaining_r;
  assign inv50             = inv_r[0];
  assign inv100            = inv_r[1];
  assign inv500            = inv_r[2];
  assign inv1000           = inv_r[3];
  assign hopper.eject_req  = eject_req_r;
  assign hopper.eject_note = note_r;

endmodule
